// File: rtl/ppu_vga_pkg.sv
// Purpose: shared 640x480@60 timing constants and the NES colour type for the PPU scanout path.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Contents: H/V visible, porch, sync and total counts, sync spans, the 64-pixel border
//           of the 2x-scaled 256-wide NES window, and nes_rgb_t (4 bits per channel).
package ppu_vga_pkg;

  // Horizontal timing, in pixel ticks.
  localparam logic [9:0] H_VISIBLE    = 10'd640;
  localparam logic [9:0] H_FRONT      = 10'd16;
  localparam logic [9:0] H_SYNC       = 10'd96;
  localparam logic [9:0] H_BACK       = 10'd48;
  localparam logic [9:0] H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;  // 800
  localparam logic [9:0] H_SYNC_START = H_VISIBLE + H_FRONT;                    // 656
  localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;                  // 752, exclusive

  // Vertical timing, in lines.
  localparam logic [9:0] V_VISIBLE    = 10'd480;
  localparam logic [9:0] V_FRONT      = 10'd10;
  localparam logic [9:0] V_SYNC       = 10'd2;
  localparam logic [9:0] V_BACK       = 10'd33;
  localparam logic [9:0] V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;  // 525
  localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FRONT;                    // 490
  localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;                  // 492, exclusive

  // NES picture: 256 columns doubled to 512 pixels, centred with a 64-pixel border.
  localparam logic [9:0] NES_BORDER   = 10'd64;
  localparam logic [9:0] NES_WIDTH    = 10'd512;
  localparam logic [9:0] NES_H_END    = NES_BORDER + NES_WIDTH;                 // 576, exclusive

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } nes_rgb_t;

endpackage

// File: rtl/nes_palette_rom.sv
// Purpose: NES 2C02 master palette, 6-bit palette index to 12-bit RGB.
// Latency: combinational.
// Backpressure: none (pure lookup).
// Ports: idx - palette index; rgb - 4-bit-per-channel colour. Unused slots read black.
module nes_palette_rom
  import ppu_vga_pkg::*;
(
  input  logic [5:0] idx,
  output nes_rgb_t   rgb
);

  always_comb begin
    rgb = 12'h000;
    case (idx)
      6'h00: rgb = 12'h777;  6'h01: rgb = 12'h00F;  6'h02: rgb = 12'h00B;  6'h03: rgb = 12'h42B;
      6'h04: rgb = 12'h908;  6'h05: rgb = 12'hA02;  6'h06: rgb = 12'hA10;  6'h07: rgb = 12'h810;
      6'h08: rgb = 12'h530;  6'h09: rgb = 12'h070;  6'h0A: rgb = 12'h060;  6'h0B: rgb = 12'h050;
      6'h0C: rgb = 12'h045;
      6'h10: rgb = 12'hBBB;  6'h11: rgb = 12'h07F;  6'h12: rgb = 12'h05F;  6'h13: rgb = 12'h64F;
      6'h14: rgb = 12'hD0C;  6'h15: rgb = 12'hE05;  6'h16: rgb = 12'hF30;  6'h17: rgb = 12'hE51;
      6'h18: rgb = 12'hA70;  6'h19: rgb = 12'h0B0;  6'h1A: rgb = 12'h0A0;  6'h1B: rgb = 12'h0A4;
      6'h1C: rgb = 12'h088;
      6'h20: rgb = 12'hFFF;  6'h21: rgb = 12'h3BF;  6'h22: rgb = 12'h68F;  6'h23: rgb = 12'h97F;
      6'h24: rgb = 12'hF7F;  6'h25: rgb = 12'hF59;  6'h26: rgb = 12'hF75;  6'h27: rgb = 12'hFA4;
      6'h28: rgb = 12'hFB0;  6'h29: rgb = 12'hBF1;  6'h2A: rgb = 12'h5D5;  6'h2B: rgb = 12'h5F9;
      6'h2C: rgb = 12'h0ED;  6'h2D: rgb = 12'h777;
      6'h30: rgb = 12'hFFF;  6'h31: rgb = 12'hAEF;  6'h32: rgb = 12'hBBF;  6'h33: rgb = 12'hDBF;
      6'h34: rgb = 12'hFBF;  6'h35: rgb = 12'hFAC;  6'h36: rgb = 12'hFDB;  6'h37: rgb = 12'hFEA;
      6'h38: rgb = 12'hFD7;  6'h39: rgb = 12'hDF7;  6'h3A: rgb = 12'hBFB;  6'h3B: rgb = 12'hBFD;
      6'h3C: rgb = 12'h0FF;  6'h3D: rgb = 12'hFDF;
      default: rgb = 12'h000;
    endcase
  end

endmodule

// File: rtl/ppu_vga_scanout.sv
// Purpose: scans a 256x240 NES framebuffer out as 2x-scaled 640x480@60 VGA with border.
// Latency: 2 pix_en ticks from counter position to pins (address stage, colour stage).
// Backpressure: none; everything advances only on pix_en and holds otherwise.
// Ports: clk/rst (async, active-high); pix_en pixel tick; fb_row/fb_col read address and
//        fb_data read data (valid 1 clk later, bits [5:0] used); vga_* sync and colour
//        pins; vblank_pulse / frame_start one-clk markers aligned with the pins.
module ppu_vga_scanout
  import ppu_vga_pkg::*;
#(
  parameter bit SYNC_POL = 1'b0
)(
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  output logic [8:0] fb_row,
  output logic [8:0] fb_col,
  input  logic [7:0] fb_data,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       vblank_pulse,
  output logic       frame_start
);

  logic [9:0] h_cnt, v_cnt;
  logic       h_last, v_last, in_win, in_hs, in_vs;
  logic       s1_win, s1_hs, s1_vs, s1_fs, s1_vb;
  nes_rgb_t   pal_rgb;

  // Bits [7:6] of the framebuffer byte carry no colour information.
  logic unused_fb_hi;
  assign unused_fb_hi = &{1'b0, fb_data[7:6]};

  always_comb begin
    h_last = (h_cnt == H_TOTAL - 10'd1);
    v_last = (v_cnt == V_TOTAL - 10'd1);
    in_win = (h_cnt >= NES_BORDER) && (h_cnt < NES_H_END) && (v_cnt < V_VISIBLE);
    in_hs  = (h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END);
    in_vs  = (v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END);
  end

  // Raster position counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Stage 1: framebuffer address plus the flags that must travel with this pixel.
  // The address only moves inside the window so the memory sees a stable address in the border.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_row <= '0;
      fb_col <= '0;
      s1_win <= 1'b0;
      s1_hs  <= ~SYNC_POL;
      s1_vs  <= ~SYNC_POL;
      s1_fs  <= 1'b0;
      s1_vb  <= 1'b0;
    end else if (pix_en) begin
      if (in_win) begin
        fb_row <= 9'(v_cnt >> 1);
        fb_col <= 9'((h_cnt - NES_BORDER) >> 1);
      end
      s1_win <= in_win;
      s1_hs  <= in_hs ? SYNC_POL : ~SYNC_POL;
      s1_vs  <= in_vs ? SYNC_POL : ~SYNC_POL;
      s1_fs  <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
      s1_vb  <= (h_cnt == 10'd0) && (v_cnt == V_VISIBLE);
    end
  end

  nes_palette_rom u_palette (
    .idx (fb_data[5:0]),
    .rgb (pal_rgb)
  );

  // Stage 2: colour and syncs to the pins. Pulses are gated by pix_en so they last one clk
  // even when pix_en is sparse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_r        <= '0;
      vga_g        <= '0;
      vga_b        <= '0;
      vga_hsync    <= ~SYNC_POL;
      vga_vsync    <= ~SYNC_POL;
      vblank_pulse <= 1'b0;
      frame_start  <= 1'b0;
    end else begin
      vblank_pulse <= pix_en & s1_vb;
      frame_start  <= pix_en & s1_fs;
      if (pix_en) begin
        vga_r     <= s1_win ? pal_rgb.r : 4'd0;
        vga_g     <= s1_win ? pal_rgb.g : 4'd0;
        vga_b     <= s1_win ? pal_rgb.b : 4'd0;
        vga_hsync <= s1_hs;
        vga_vsync <= s1_vs;
      end
    end
  end

endmodule

// File: tb/tb_ppu_vga_scanout.sv
// Purpose: self-checking bench for ppu_vga_scanout against a position-based reference model.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_ppu_vga_scanout;

  localparam bit POL  = 1'b0;
  localparam bit NPOL = ~POL;
  localparam int HT = 800;
  localparam int VT = 525;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       rst;
  logic       pix_en;
  logic [8:0] fb_row, fb_col;
  logic [7:0] fb_data;
  logic       hs, vs, vb, fs;
  logic [3:0] r, g, b;

  int checks = 0;
  int errors = 0;

  // Framebuffer contents, row-major 240 x 256 bytes.
  logic [7:0] mem [240*256];

  // Canonical NES palette in 8-bit-per-channel form; pins carry the top nibble of each channel.
  logic [23:0] nes888 [64] = '{
    24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC, 24'h940084, 24'hA80020, 24'hA81000, 24'h881400,
    24'h503000, 24'h007800, 24'h006800, 24'h005800, 24'h004058, 24'h000000, 24'h000000, 24'h000000,
    24'hBCBCBC, 24'h0078F8, 24'h0058F8, 24'h6844FC, 24'hD800CC, 24'hE40058, 24'hF83800, 24'hE45C10,
    24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844, 24'h008888, 24'h000000, 24'h000000, 24'h000000,
    24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8, 24'hF878F8, 24'hF85898, 24'hF87858, 24'hFCA044,
    24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898, 24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
    24'hFCFCFC, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8, 24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0, 24'hFCE0A8,
    24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8, 24'h00FCFC, 24'hF8D8F8, 24'h000000, 24'h000000
  };

  always #5 clk = ~clk;

  // Read data follows the registered address, so it is settled well before the next pix_en.
  assign fb_data = mem[int'(fb_row) * 256 + int'(fb_col)];

  ppu_vga_scanout #(.SYNC_POL(POL)) dut (
    .clk          (clk),
    .rst          (rst),
    .pix_en       (pix_en),
    .fb_row       (fb_row),
    .fb_col       (fb_col),
    .fb_data      (fb_data),
    .vga_hsync    (hs),
    .vga_vsync    (vs),
    .vga_r        (r),
    .vga_g        (g),
    .vga_b        (b),
    .vblank_pulse (vb),
    .frame_start  (fs)
  );

  // Reference model state: n = pix_en ticks since reset release; after tick n the
  // address stage shows raster position n-1 and the pins show position n-2.
  int         n;
  logic [8:0] m_row, m_col;
  logic [11:0] e_rgb;
  logic       e_hs, e_vs, e_fs, e_vb;
  int         line_err, first_bad, hs_ticks, vs_ticks, vb_seen, vb_q, last_fs;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic [11:0] pal12(input logic [7:0] d);
    logic [23:0] c;
    c = nes888[d[5:0]];
    return {c[23:20], c[15:12], c[7:4]};
  endfunction

  task automatic set_expect(input int qq);
    int q, h, v;
    if (qq < 0) begin
      e_rgb = 12'h000; e_hs = NPOL; e_vs = NPOL; e_fs = 1'b0; e_vb = 1'b0;
    end else begin
      q = qq % FRAME; h = q % HT; v = q / HT;
      e_hs = (h >= 656 && h < 752) ? POL : NPOL;
      e_vs = (v >= 490 && v < 492) ? POL : NPOL;
      e_fs = (q == 0);
      e_vb = (q == 480 * HT);
      e_rgb = (h >= 64 && h < 576 && v < 480) ? pal12(mem[(v / 2) * 256 + (h - 64) / 2]) : 12'h000;
    end
  endtask

  task automatic compare_now(input bit live);
    if ({r, g, b} !== e_rgb || hs !== e_hs || vs !== e_vs || fb_row !== m_row || fb_col !== m_col ||
        fs !== (live & e_fs) || vb !== (live & e_vb)) begin
      if (line_err == 0) first_bad = (n - 2) % HT;
      line_err++;
    end
  endtask

  task automatic model_reset();
    n = 0; m_row = '0; m_col = '0;
    line_err = 0; hs_ticks = 0; vs_ticks = 0; vb_seen = 0; vb_q = -1; last_fs = -1;
    set_expect(-1);
  endtask

  task automatic frame_mark();
    if (last_fs >= 0) begin
      chk("frame_period", n - last_fs, FRAME);
      chk("vsync_ticks", vs_ticks, 1600);
      chk("vblank_count", vb_seen, 1);
      chk("vblank_pos", vb_q, 480 * HT);
    end
    last_fs = n; vs_ticks = 0; vb_seen = 0; vb_q = -1;
  endtask

  task automatic line_done(input int v);
    chk($sformatf("line_px v=%0d first_bad_h=%0d", v, first_bad), line_err, 0);
    chk($sformatf("hsync_ticks v=%0d", v), hs_ticks, 96);
    line_err = 0; hs_ticks = 0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
      compare_now(1'b0);
    end
  endtask

  task automatic tick();
    int q, h, v;
    @(negedge clk); pix_en = 1'b1;
    @(posedge clk); #1; pix_en = 1'b0;
    n++;
    q = (n - 1) % FRAME; h = q % HT; v = q / HT;
    if (h >= 64 && h < 576 && v < 480) begin
      m_row = 9'(v / 2);
      m_col = 9'((h - 64) / 2);
    end
    set_expect(n - 2);
    compare_now(1'b1);
    if (n >= 2) begin
      q = (n - 2) % FRAME; h = q % HT; v = q / HT;
      if (hs === POL) hs_ticks++;
      if (vs === POL) vs_ticks++;
      if (vb === 1'b1) begin vb_seen++; vb_q = q; end
      if (fs === 1'b1) frame_mark();
      if (v < 2 && (h == 63 || h == 576))
        chk($sformatf("border_px h=%0d v=%0d", h, v), {r, g, b}, 12'h000);
      if (v < 2 && h >= 64 && h <= 67)
        chk($sformatf("pal16_px h=%0d v=%0d", h, v), {r, g, b}, 12'hF30);
      if (h == HT - 1) line_done(v);
    end
  endtask

  initial begin
    rst = 1'b1;
    pix_en = 1'b0;
    for (int i = 0; i < 240 * 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h16;   // row 0, col 0
    mem[1] = 8'hD6;   // row 0, col 1: same index with the ignored top bits set
    model_reset();

    // Reset state.
    @(negedge clk); @(negedge clk);
    chk("rst_rgb", {r, g, b}, 12'h000);
    chk("rst_hsync", hs, NPOL);
    chk("rst_vsync", vs, NPOL);
    chk("rst_fb_row", fb_row, 9'd0);
    chk("rst_fb_col", fb_col, 9'd0);
    chk("rst_vblank", vb, 1'b0);
    chk("rst_frame_start", fs, 1'b0);
    rst = 1'b0;

    // Pixel tick every 4th clk for the first lines, with a 50-clk stall mid-line 1.
    for (int t = 0; t < 2400; t++) begin
      tick();
      if (n == HT + 200) begin
        idle(50);
        chk("stall_rgb", {r, g, b}, e_rgb);
        chk("stall_fb_col", fb_col, m_col);
        chk("stall_hsync", hs, e_hs);
        chk("stall_pulses", {fs, vb}, 2'b00);
      end else begin
        idle(3);
      end
    end

    // Back-to-back ticks through the rest of frame 0 and into frame 1 up to h=300, v=200.
    while (n < FRAME + 200 * HT + 300) tick();

    // Mid-frame reset, with pix_en toggling while reset is held.
    chk("pre_rst_partial_line", line_err, 0);
    @(negedge clk); rst = 1'b1; #1;
    chk("midrst_rgb", {r, g, b}, 12'h000);
    chk("midrst_hsync", hs, NPOL);
    chk("midrst_vsync", vs, NPOL);
    chk("midrst_fb", {fb_row, fb_col}, 18'd0);
    chk("midrst_pulses", {fs, vb}, 2'b00);
    pix_en = 1'b1;
    @(negedge clk); @(negedge clk);
    pix_en = 1'b0;
    chk("rst_hold_rgb", {r, g, b}, 12'h000);
    chk("rst_hold_fb", {fb_row, fb_col}, 18'd0);
    rst = 1'b0;
    model_reset();

    tick();
    chk("fs_after_1st_tick", fs, 1'b0);
    idle(1);
    tick();
    chk("fs_after_2nd_tick", fs, 1'b1);
    idle(1);
    chk("fs_one_clk", fs, 1'b0);
    for (int t = 0; t < 2400; t++) begin
      tick();
      idle(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
